// File: rtl/fp_fmt_pkg.sv
// ============================================================================
//  Module      : fp_fmt_pkg
//  Description : FP16 / FP8-E4M3 format constants and the converter result type.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_fmt_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;

    localparam int FP8_EXP_W  = 4;
    localparam int FP8_MAN_W  = 3;
    localparam int FP8_BIAS   = 7;

    localparam logic [6:0] FP8_MAXPOS = 7'h7E;
    localparam logic [6:0] FP8_NAN    = 7'h7F;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
        logic       unf;
    } conv_result_t;

endpackage

`default_nettype wire

// File: rtl/fp16_to_fp8_conv.sv
// ============================================================================
//  Module      : fp16_to_fp8_conv
//  Description : Combinational FP16 -> FP8 E4M3 conversion (RNE, saturate, FTZ).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp16_to_fp8_conv
    import fp_fmt_pkg::*;
(
    input  logic [15:0]  data_i,
    output conv_result_t result_o
);

    logic                  w_sign;
    logic [FP16_EXP_W-1:0] w_exp;
    logic [FP16_MAN_W-1:0] w_man;
    logic                  w_round_up;
    logic [3:0]            w_man_r;
    logic [5:0]            w_exp_r;

    assign w_sign = data_i[15];
    assign w_exp  = data_i[14:10];
    assign w_man  = data_i[9:0];

    always_comb begin
        w_round_up = w_man[6] & ((|w_man[5:0]) | w_man[7]);
        // Bit 3 of the rounded mantissa is the carry into the exponent.
        w_man_r    = {1'b0, w_man[9:7]} + {3'b000, w_round_up};
        w_exp_r    = {1'b0, w_exp} - 6'd8 + {5'd0, w_man_r[3]};

        result_o.data = {w_sign, 7'h00};
        result_o.ovf  = 1'b0;
        result_o.unf  = 1'b0;

        if (w_exp == '1) begin
            if (w_man != '0) begin
                result_o.data = {w_sign, FP8_NAN};
            end else begin
                result_o.data = {w_sign, FP8_MAXPOS};
                result_o.ovf  = 1'b1;
            end
        end else if (w_exp == '0) begin
            result_o.data = {w_sign, 7'h00};
        end else if (w_exp <= 5'd8) begin
            result_o.unf  = 1'b1;
        end else if ((w_exp_r > 6'd15) || ((w_exp_r == 6'd15) && (w_man_r[2:0] == 3'b111))) begin
            result_o.data = {w_sign, FP8_MAXPOS};
            result_o.ovf  = 1'b1;
        end else begin
            result_o.data = {w_sign, w_exp_r[3:0], w_man_r[2:0]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp8_result_packer.sv
// ============================================================================
//  Module      : fp8_result_packer
//  Description : FP16 -> FP8 packer with 2-entry output FIFO, sticky flags, counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp8_result_packer
    import fp_fmt_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             ovf_flag,
    output logic             unf_flag,
    output logic [CNT_W-1:0] conv_count,
    input  logic             clr_flags
);

    conv_result_t     w_conv;
    logic             w_push;
    logic             w_pop;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    fp16_to_fp8_conv u_conv (
        .data_i   (in_data),
        .result_o (w_conv)
    );

    assign in_ready   = rst_n & ena & (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign out_byte   = mem_q[head_q];
    assign ovf_flag   = ovf_q;
    assign unf_flag   = unf_q;
    assign conv_count = cnt_q;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready & ena;

    always_comb begin
        head_d  = head_q ^ w_pop;
        tail_d  = tail_q ^ w_push;
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 2'd1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 2'd1;
        end

        ovf_d = ovf_q;
        unf_d = unf_q;
        cnt_d = cnt_q;
        // Clear outranks a coincident accept; the word still enters the FIFO.
        if (ena && clr_flags) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            cnt_d = '0;
        end else if (w_push) begin
            ovf_d = ovf_q | w_conv.ovf;
            unf_d = unf_q | w_conv.unf;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            cnt_q   <= cnt_d;
            if (w_push) begin
                mem_q[tail_q] <= w_conv.data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp8_result_packer.sv
// ============================================================================
//  Module      : tb_fp8_result_packer
//  Description : Self-checking bench for fp8_result_packer against a numeric model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp8_result_packer;

    logic        clk = 1'b0;
    logic        rst_n, ena, in_valid, out_ready, clr_flags;
    logic [15:0] in_data;
    logic        in_ready, out_valid, ovf_flag, unf_flag;
    logic [7:0]  out_byte;
    logic [7:0]  conv_count;

    int          n_chk = 0;
    int          n_err = 0;

    logic [7:0]  m_q [$];
    logic        m_ovf, m_unf;
    int          m_cnt;

    always #5 clk = ~clk;

    fp8_result_packer #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .ovf_flag   (ovf_flag),
        .unf_flag   (unf_flag),
        .conv_count (conv_count),
        .clr_flags  (clr_flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Numeric reference: quantise the FP16 significand to 3 fraction bits (RNE).
    // Returns {ovf, unf, byte}.
    function automatic logic [9:0] ref_conv(input logic [15:0] w);
        logic       s;
        int         e, m, sig, q, rem, ex;
        logic [3:0] eb;
        logic [2:0] mb;
        s = w[15];
        e = int'(w[14:10]);
        m = int'(w[9:0]);
        if (e == 31) return (m != 0) ? {2'b00, s, 7'h7F} : {2'b10, s, 7'h7E};
        if (e == 0) return {2'b00, s, 7'h00};
        ex = (e - 15) + 7;
        if (ex < 1) return {2'b01, s, 7'h00};
        sig = 1024 + m;
        q   = sig / 128;
        rem = sig % 128;
        if (rem > 64 || (rem == 64 && (q % 2) == 1)) q = q + 1;
        if (q == 16) begin
            q  = 8;
            ex = ex + 1;
        end
        if (ex > 15 || (ex == 15 && q == 15)) return {2'b10, s, 7'h7E};
        eb = ex[3:0];
        mb = 3'(q - 8);
        return {2'b00, s, eb, mb};
    endfunction

    task automatic compare_all();
        check("in_ready", in_ready, (rst_n && ena && m_q.size() < 2));
        check("out_valid", out_valid, (m_q.size() > 0));
        if (m_q.size() > 0) check("out_byte", out_byte, m_q[0]);
        check("ovf_flag", ovf_flag, m_ovf);
        check("unf_flag", unf_flag, m_unf);
        check("conv_count", conv_count, m_cnt);
    endtask

    task automatic tick();
        logic       acc, pp;
        logic [9:0] r;
        acc = rst_n && ena && in_valid && (m_q.size() < 2);
        pp  = rst_n && ena && out_ready && (m_q.size() > 0);
        r   = ref_conv(in_data);
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_cnt = 0;
        end else if (ena) begin
            if (pp) void'(m_q.pop_front());
            if (acc) m_q.push_back(r[7:0]);
            if (clr_flags) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
                m_cnt = 0;
            end else if (acc) begin
                m_ovf = m_ovf | r[9];
                m_unf = m_unf | r[8];
                if (m_cnt != 255) m_cnt++;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    // Push one word into an empty FIFO, check it against constants, then pop it.
    task automatic push_check(input logic [15:0] d, input logic [7:0] eb,
                              input logic eo, input logic eu, input logic clr_after);
        in_valid = 1'b1; in_data = d; out_ready = 1'b0; clr_flags = 1'b0;
        tick();
        check("dir_byte", out_byte, eb);
        check("dir_ovf", ovf_flag, eo);
        check("dir_unf", unf_flag, eu);
        in_valid = 1'b0; out_ready = 1'b1; clr_flags = clr_after;
        tick();
        clr_flags = 1'b0;
    endtask

    logic [15:0] dir_in  [11] = '{16'h3C40, 16'h3CC0, 16'h3FC0, 16'h3DE0, 16'h5F00, 16'h5F80,
                                  16'hFC00, 16'h7E00, 16'h2000, 16'h8000, 16'h0001};
    logic [7:0]  dir_out [11] = '{8'h38, 8'h3A, 8'h40, 8'h3C, 8'h7E, 8'h7E,
                                  8'hFE, 8'h7F, 8'h00, 8'h80, 8'h00};
    logic        dir_ovf [11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic        dir_unf [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        logic [7:0] saved;
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        clr_flags = 1'b0; in_data = 16'h0000;
        m_ovf = 1'b0; m_unf = 1'b0; m_cnt = 0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_count", conv_count, 8'h00);
        rst_n = 1'b1;
        tick();

        // Basic conversions
        push_check(16'h3C00, 8'h38, 1'b0, 1'b0, 1'b0);
        push_check(16'hC000, 8'hC0, 1'b0, 1'b0, 1'b0);
        push_check(16'h2400, 8'h08, 1'b0, 1'b0, 1'b0);
        check("basic_count", conv_count, 8'd3);
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;

        // Rounding, saturation and specials
        for (int i = 0; i < 11; i++) begin
            push_check(dir_in[i], dir_out[i], dir_ovf[i], dir_unf[i], 1'b1);
        end

        // Backpressure: third word is held until a slot frees
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h3C00; tick();
        check("bp_ready1", in_ready, 1'b1);
        in_data = 16'h4000; tick();
        check("bp_ready2", in_ready, 1'b0);
        in_data = 16'h4200; tick();
        check("bp_held", conv_count, 8'd2);
        out_ready = 1'b1; tick();
        check("bp_head2", out_byte, 8'h40);
        check("bp_ready_back", in_ready, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Back-to-back push/pop at occupancy 1
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h3C00; tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'($urandom);
            tick();
            check("pp_valid", out_valid, 1'b1);
            check("pp_byte", out_byte, ref_conv(in_data) & 10'h0FF);
        end
        in_valid = 1'b0; tick();

        // Enable low freezes everything
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h4400; tick();
        saved = out_byte;
        ena = 1'b0; out_ready = 1'b1; clr_flags = 1'b1; in_data = 16'h4800;
        for (int i = 0; i < 3; i++) tick();
        check("ena_byte", out_byte, saved);
        check("ena_valid", out_valid, 1'b1);
        ena = 1'b1; clr_flags = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset with two entries queued
        out_ready = 1'b0; in_valid = 1'b1; tick(); tick();
        check("q2_valid", out_valid, 1'b1);
        rst_n = 1'b0; tick();
        check("midrst_valid", out_valid, 1'b0);
        rst_n = 1'b1; in_valid = 1'b0; tick();

        // Clear coincident with an overflowing accept
        in_valid = 1'b1; in_data = 16'h5F80; clr_flags = 1'b1; tick();
        check("clr_ovf", ovf_flag, 1'b0);
        check("clr_byte", out_byte, 8'h7E);
        in_valid = 1'b0; clr_flags = 1'b0; out_ready = 1'b1; tick();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            ena       = ($urandom_range(0, 7) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            clr_flags = ($urandom_range(0, 31) == 0);
            in_data   = 16'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
